// File: rtl/boa_mem_arbiter.sv
// boa_mem_arbiter
// ---------------
// Shares a single memory / peripheral bus port between two requesters:
// port 0 (instruction fetch) and port 1 (data load/store). An idle bus is
// granted combinationally in the same cycle. A transaction that does not
// complete in its first cycle locks the bus to its port until m_ready.
//
// Build option:
//   BOA_ARB_ROUND_ROBIN_EN  undefined -> conflicts always go to port 1
//                           defined   -> conflicts go to the port that did
//                                        not complete the last transaction
//
// Ports:
//   clk                system clock, rising edge
//   rst                asynchronous active-low reset
//   pN_re              port N read request
//   pN_we[3:0]         port N byte write enables
//   pN_addr[29:0]      port N word address (byte address [31:2])
//   pN_wdata[31:0]     port N write data
//   pN_rdata[31:0]     port N read data (m_rdata broadcast)
//   pN_ready           port N transaction complete
//   m_re/m_we/m_addr/m_wdata   shared bus request, from the granted port
//   m_rdata/m_ready            shared bus response

module boa_mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_re,
  input  logic [3:0]  p0_we,
  input  logic [29:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  output logic        p0_ready,
  input  logic        p1_re,
  input  logic [3:0]  p1_we,
  input  logic [29:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  output logic        p1_ready,
  output logic        m_re,
  output logic [3:0]  m_we,
  output logic [29:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  logic [1:0] state_q, state_d;
  logic       p0_req, p1_req;
  logic       gnt_valid;
  logic       gnt_port;
  logic       conflict_winner;

  assign p0_req = p0_re | (p0_we != 4'b0000);
  assign p1_req = p1_re | (p1_we != 4'b0000);

`ifdef BOA_ARB_ROUND_ROBIN_EN
  // Port that completed the most recent transaction; resets to port 0 so
  // the first conflict goes to port 1, matching the fixed-priority build.
  logic last_q, last_d;

  assign last_d = (gnt_valid && m_ready) ? gnt_port : last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end

  assign conflict_winner = ~last_q;
`else
  assign conflict_winner = 1'b1;
`endif

  // Grant selection. A locked state overrides any request pattern, so a
  // requester that drops its request mid-transaction keeps the bus anyway.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_port  = 1'b0;
    case (state_q)
      LOCK0: begin
        gnt_valid = 1'b1;
        gnt_port  = 1'b0;
      end
      LOCK1: begin
        gnt_valid = 1'b1;
        gnt_port  = 1'b1;
      end
      default: begin
        if (p0_req && p1_req) begin
          gnt_valid = 1'b1;
          gnt_port  = conflict_winner;
        end else if (p1_req) begin
          gnt_valid = 1'b1;
          gnt_port  = 1'b1;
        end else if (p0_req) begin
          gnt_valid = 1'b1;
          gnt_port  = 1'b0;
        end
      end
    endcase
  end

  // Bus mux; drive zeros when nothing is granted so the bus sits quiet.
  always_comb begin
    m_re    = 1'b0;
    m_we    = 4'b0000;
    m_addr  = 30'd0;
    m_wdata = 32'd0;
    if (gnt_valid) begin
      if (gnt_port) begin
        m_re    = p1_re;
        m_we    = p1_we;
        m_addr  = p1_addr;
        m_wdata = p1_wdata;
      end else begin
        m_re    = p0_re;
        m_we    = p0_we;
        m_addr  = p0_addr;
        m_wdata = p0_wdata;
      end
    end
  end

  assign p0_rdata = m_rdata;
  assign p1_rdata = m_rdata;
  assign p0_ready = m_ready & gnt_valid & ~gnt_port;
  assign p1_ready = m_ready & gnt_valid &  gnt_port;

  // Lock only when the granted transaction did not finish this cycle; a
  // completion returns to IDLE so the next cycle re-arbitrates with no gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid && !m_ready) begin
          state_d = gnt_port ? LOCK1 : LOCK0;
        end
      end
      LOCK0, LOCK1: begin
        if (m_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_boa_mem_arbiter.sv
// Directed bench for boa_mem_arbiter. Inputs change 1 ns after the rising
// edge; outputs (combinational from inputs and state) are sampled on the
// falling edge or a few ns after an asynchronous reset event.
`timescale 1ns/1ps
module tb_boa_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_re, p1_re;
  logic [3:0]  p0_we, p1_we;
  logic [29:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_ready, p1_ready;
  logic        m_re;
  logic [3:0]  m_we;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  boa_mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .p0_re    (p0_re),
    .p0_we    (p0_we),
    .p0_addr  (p0_addr),
    .p0_wdata (p0_wdata),
    .p0_rdata (p0_rdata),
    .p0_ready (p0_ready),
    .p1_re    (p1_re),
    .p1_we    (p1_we),
    .p1_addr  (p1_addr),
    .p1_wdata (p1_wdata),
    .p1_rdata (p1_rdata),
    .p1_ready (p1_ready),
    .m_re     (m_re),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    p0_re = 1'b0; p0_we = 4'h0; p0_addr = 30'd0; p0_wdata = 32'd0;
    p1_re = 1'b0; p1_we = 4'h0; p1_addr = 30'd0; p1_wdata = 32'd0;
  endtask

  logic exp_w [3];

  initial begin
`ifdef BOA_ARB_ROUND_ROBIN_EN
    exp_w[0] = 1'b1; exp_w[1] = 1'b0; exp_w[2] = 1'b1;
`else
    exp_w[0] = 1'b1; exp_w[1] = 1'b1; exp_w[2] = 1'b1;
`endif
    rst = 1'b0;
    idle_ports();
    m_rdata = 32'd0;
    m_ready = 1'b0;

    // Reset state, no requests
    #2;
    chk("rst_m_re", {31'd0, m_re}, 32'd0);
    chk("rst_m_we", {28'd0, m_we}, 32'd0);
    chk("rst_m_addr", {2'd0, m_addr}, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_p0_ready", {31'd0, p0_ready}, 32'd0);
    chk("rst_p1_ready", {31'd0, p1_ready}, 32'd0);
    next_cyc();
    rst = 1'b1;

    // Port 0 read of byte address 0x100, memory ready on the third cycle
    for (int c = 1; c <= 3; c++) begin
      next_cyc();
      p0_re   = 1'b1;
      p0_addr = 30'h40;
      m_ready = (c == 3);
      m_rdata = 32'h1000_0000 + 32'(c);
      @(negedge clk);
      chk($sformatf("t1_m_addr_c%0d", c), {2'd0, m_addr}, 32'h40);
      chk($sformatf("t1_m_re_c%0d", c), {31'd0, m_re}, 32'd1);
      chk($sformatf("t1_p0_ready_c%0d", c), {31'd0, p0_ready}, (c == 3) ? 32'd1 : 32'd0);
      chk($sformatf("t1_p1_ready_c%0d", c), {31'd0, p1_ready}, 32'd0);
    end
    chk("t1_p0_rdata", p0_rdata, 32'h1000_0003);
    $display("txn p0 read addr=0x40 ready after 3 cycles");

    // Port 1 full-word write completing in a single cycle
    next_cyc();
    idle_ports();
    p1_we = 4'hF; p1_addr = 30'h55; p1_wdata = 32'hdead_beef;
    m_ready = 1'b1; m_rdata = 32'hcafe_0001;
    @(negedge clk);
    chk("t2_m_we", {28'd0, m_we}, 32'hF);
    chk("t2_m_wdata", m_wdata, 32'hdead_beef);
    chk("t2_m_addr", {2'd0, m_addr}, 32'h55);
    chk("t2_p1_ready", {31'd0, p1_ready}, 32'd1);
    chk("t2_p0_ready", {31'd0, p0_ready}, 32'd0);
    chk("t2_p1_rdata", p1_rdata, 32'hcafe_0001);
    $display("txn p1 write addr=0x55 data=0xdeadbeef single cycle");

    // Port 0 read right after: gets the bus at once, so no lock was left
    next_cyc();
    idle_ports();
    p0_re = 1'b1; p0_addr = 30'h7; m_ready = 1'b0;
    @(negedge clk);
    chk("t2b_m_addr", {2'd0, m_addr}, 32'h7);
    chk("t2b_m_re", {31'd0, m_re}, 32'd1);
    chk("t2b_p0_ready_wait", {31'd0, p0_ready}, 32'd0);
    next_cyc();
    m_ready = 1'b1;
    @(negedge clk);
    chk("t2b_p0_ready", {31'd0, p0_ready}, 32'd1);
    $display("txn p0 read addr=0x7 two cycles");

    // Conflict with m_ready every cycle
    for (int c = 0; c < 3; c++) begin
      next_cyc();
      p0_re = 1'b1; p0_addr = 30'h100;
      p1_re = 1'b1; p1_addr = 30'h200;
      m_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("t3_m_addr_c%0d", c), {2'd0, m_addr}, exp_w[c] ? 32'h200 : 32'h100);
      chk($sformatf("t3_p1_ready_c%0d", c), {31'd0, p1_ready}, {31'd0, exp_w[c]});
      chk($sformatf("t3_p0_ready_c%0d", c), {31'd0, p0_ready}, {31'd0, ~exp_w[c]});
      $display("txn conflict cycle %0d expected winner p%0d", c, exp_w[c]);
    end
    next_cyc();
    p1_re = 1'b0; p1_addr = 30'd0;
    @(negedge clk);
    chk("t3_p0_served_addr", {2'd0, m_addr}, 32'h100);
    chk("t3_p0_served_ready", {31'd0, p0_ready}, 32'd1);
    $display("txn conflict p0 served after p1 deasserts");

    // Lock hold: port 0 owns the bus while port 1 waits
    next_cyc();
    idle_ports();
    p0_re = 1'b1; p0_addr = 30'h10; m_ready = 1'b0;
    @(negedge clk);
    chk("t4_a_addr", {2'd0, m_addr}, 32'h10);
    next_cyc();
    p1_we = 4'h3; p1_addr = 30'h20; p1_wdata = 32'h0000_abcd;
    @(negedge clk);
    chk("t4_b_addr", {2'd0, m_addr}, 32'h10);
    chk("t4_b_p1_ready", {31'd0, p1_ready}, 32'd0);
    next_cyc();
    m_ready = 1'b1;
    @(negedge clk);
    chk("t4_c_addr", {2'd0, m_addr}, 32'h10);
    chk("t4_c_p0_ready", {31'd0, p0_ready}, 32'd1);
    chk("t4_c_p1_ready", {31'd0, p1_ready}, 32'd0);
    next_cyc();
    p0_re = 1'b0; p0_addr = 30'd0;
    @(negedge clk);
    chk("t4_d_addr", {2'd0, m_addr}, 32'h20);
    chk("t4_d_we", {28'd0, m_we}, 32'h3);
    chk("t4_d_p1_ready", {31'd0, p1_ready}, 32'd1);
    $display("txn lock hold p0 then p1 write");

    // Reset while port 1 holds the lock
    next_cyc();
    idle_ports();
    p1_re = 1'b1; p1_addr = 30'h30; m_ready = 1'b0;
    next_cyc();
    p0_re = 1'b1; p0_addr = 30'h31;
    @(negedge clk);
    chk("t5_locked_addr", {2'd0, m_addr}, 32'h30);
    #1;
    rst = 1'b0; p1_re = 1'b0; p1_addr = 30'd0; m_ready = 1'b1;
    #1;
    chk("t5_rst_addr", {2'd0, m_addr}, 32'h31);
    chk("t5_rst_p1_ready", {31'd0, p1_ready}, 32'd0);
    chk("t5_rst_p0_ready", {31'd0, p0_ready}, 32'd1);
    next_cyc();
    #2;
    rst = 1'b1; m_ready = 1'b0;
    #1;
    chk("t5_post_addr", {2'd0, m_addr}, 32'h31);
    chk("t5_post_re", {31'd0, m_re}, 32'd1);
    next_cyc();
    m_ready = 1'b1;
    @(negedge clk);
    chk("t5_post_p0_ready", {31'd0, p0_ready}, 32'd1);
    $display("txn reset during p1 lock, p0 served after release");

    // Quiet bus afterwards
    next_cyc();
    idle_ports();
    @(negedge clk);
    chk("end_m_re", {31'd0, m_re}, 32'd0);
    chk("end_m_addr", {2'd0, m_addr}, 32'd0);
    chk("end_p0_ready", {31'd0, p0_ready}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/boa_mem_arbiter.md
Name: boa_mem_arbiter

Overview:
- Shares one memory bus port between two requesters: port 0 is instruction fetch, port 1 is data / load-store.
- Sits between the IF/MEM pipeline stages and a single-ported memory or peripheral bus.
- Grants are zero-latency on an idle bus.
- An issued transaction holds the bus until memory asserts ready.
- Fixed priority to port 1 by default; round-robin when the optional feature is compiled in.

Parameters:
- none (address width fixed at 30 bits [31:2], data width fixed at 32 bits)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- p0_re  in  1  port 0 read request
- p0_we  in  4  port 0 byte write enables
- p0_addr  in  30  port 0 word address [31:2]
- p0_wdata  in  32  port 0 write data
- p0_rdata  out  32  port 0 read data
- p0_ready  out  1  port 0 transaction complete
- p1_re, p1_we, p1_addr, p1_wdata, p1_rdata, p1_ready  (same as port 0, for port 1)
- m_re  out  1  shared bus read request
- m_we  out  4  shared bus byte write enables
- m_addr  out  30  shared bus word address
- m_wdata  out  32  shared bus write data
- m_rdata  in  32  shared bus read data
- m_ready  in  1  shared bus transaction complete

Behaviour:
- Request definition: pN_req = pN_re | (pN_we != 0).
- FSM states: IDLE, LOCK0, LOCK1. Reset state is IDLE.
- Reset values (rst=0, combinational outputs with no requests): m_re=0, m_we=0, m_addr=0, m_wdata=0, p0_ready=0, p1_ready=0. In the RR build, the last-grant register resets to port 0, so port 1 wins the first conflict.
- Grant selection:
  - IDLE: grant is combinational, same cycle. With one request, that port wins. With both, port 1 wins (fixed-priority build). With neither, the m_* request outputs are 0.
  - LOCKn: grant = n regardless of other requests.
- Muxing:
  - m_re, m_we, m_addr and m_wdata = the granted port's signals.
  - m_rdata is broadcast to both p0_rdata and p1_rdata.
  - pN_ready = m_ready & (grant==N).
  - A non-granted port always sees ready=0.
- Transitions:
  - IDLE -> LOCKn when port n is granted and m_ready=0.
  - IDLE stays IDLE when the grant completes the same cycle (m_ready=1): single-cycle transaction, no lock.
  - LOCKn -> IDLE when m_ready=1.
  - Back-to-back: on the cycle after completion, arbitration is re-run from IDLE. No dead cycle is required, since IDLE grants combinationally.
- Requester contract: hold re/we/addr/wdata stable from request until pN_ready. Dropping a request while locked is a protocol violation; the arbiter keeps the lock until m_ready.
- Simultaneous events:
  - New request on the losing port during completion: it waits until the next cycle's arbitration.
  - Both ports requesting continuously in the fixed-priority build: port 0 starves. This is accepted; the RR build fixes it.
- Reset mid-transaction: the FSM returns to IDLE asynchronously and the lock is dropped. Outputs follow the IDLE grant rules immediately.
- Latency: 0 cycles arbitration overhead; total latency equals the memory latency.

Optional Feature:
- Macro: BOA_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-grant register is updated on each completed transaction (m_ready=1) to the completing port.
  - On an IDLE conflict, the port not equal to last-grant wins.
  - Single requests are unaffected.
- Undefined: no last-grant register; fixed priority to port 1.

Test Plan:
- Single port 0 read, addr=0x0000_0100>>2, memory ready after 3 cycles:
  - m_addr=0x40 for 3 cycles; state LOCK0.
  - p0_ready=1 only on cycle 3; p0_rdata=m_rdata; p1_ready=0 throughout.
- Port 1 write, we=4'b1111, wdata=0xdead_beef, m_ready=1 same cycle:
  - m_we=4'hF and m_wdata=0xdead_beef in that cycle; p1_ready=1.
  - FSM stays IDLE.
- Conflict, fixed build: both request in cycle 0, m_ready=1 every cycle:
  - Cycle 0 grant=1, cycle 1 grant=1 (port 1 still requesting).
  - Port 0 is served only once port 1 deasserts.
- Conflict, RR build: both request continuously, m_ready=1 every cycle.
  - Grants alternate 1,0,1,0.
  - Each port sees ready on alternate cycles.
- Lock hold: port 0 granted with m_ready=0, then port 1 requests in the next cycle.
  - Grant stays 0 until m_ready=1.
  - Port 1 is granted in the following cycle.
- Reset mid-transaction: rst=0 while in LOCK1.
  - FSM is IDLE immediately with no clock edge; p1_ready=0.
  - After rst=1, a pending port 0 request is granted the same cycle.
